// File: rtl/game_pkg.sv
// Shared encodings and widths for the raccoon crossing game: state codes,
// datapath widths and the per-level car speed calculation.
package game_pkg;

    localparam int SPEED_W = 24;
    localparam int SCORE_W = 8;
    localparam int LEVEL_W = 3;
    localparam int LIVES_W = 3;
    localparam int FRAME_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_RUNNING   = 3'd2,
        ST_HIT       = 3'd3,
        ST_WIN       = 3'd4,
        ST_GAME_OVER = 3'd5,
        ST_PAUSED    = 3'd6
    } game_state_e;

    // Divider reload for a level; a negative or too-small result clamps to the floor.
    function automatic logic [SPEED_W-1:0] speed_for_level(
        input logic [LEVEL_W-1:0] level,
        input int                 base,
        input int                 step,
        input int                 min_speed
    );
        logic signed [SPEED_W:0] v;
        logic signed [SPEED_W:0] floor_v;
        v       = (SPEED_W+1)'(base) - (SPEED_W+1)'(step * int'(level));
        floor_v = (SPEED_W+1)'(min_speed);
        if (v < floor_v) begin
            return SPEED_W'(min_speed);
        end
        return v[SPEED_W-1:0];
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame tick from the VSync rising edge plus a loadable down-counter of ticks.
// o_Done pulses on the tick that finds the count at 1.
module frame_timer
    import game_pkg::*;
(
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_VSync,
    input  logic               i_Load,
    input  logic [FRAME_W-1:0] i_Value,
    output logic               o_Tick,
    output logic               o_Done
);

    logic               r_VSync_Prev;
    logic [FRAME_W-1:0] r_Count;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_VSync_Prev <= 1'b0;
            r_Count      <= '0;
        end else begin
            r_VSync_Prev <= i_VSync;
            // A load on the same clock as a tick wins; that tick is not counted.
            if (i_Load) begin
                r_Count <= i_Value;
            end else if (o_Tick && (r_Count != '0)) begin
                r_Count <= r_Count - 1'b1;
            end
        end
    end

    assign o_Tick = i_VSync & ~r_VSync_Prev;
    assign o_Done = o_Tick & (r_Count == FRAME_W'(1));

endmodule

// File: rtl/game_flow_ctrl.sv
// Round sequencer: start, countdown, play, hit, win and game over, with lives,
// level, score and per-level car speed. Define GAME_PAUSE_EN to add i_Pause.
module game_flow_ctrl
    import game_pkg::*;
#(
    parameter int c_LIVES            = 3,
    parameter int c_MAX_LEVEL        = 7,
    parameter int c_COUNTDOWN_FRAMES = 120,
    parameter int c_HIT_FRAMES       = 60,
    parameter int c_WIN_FRAMES       = 90,
    parameter int c_BASE_SPEED       = 100000,
    parameter int c_SPEED_STEP       = 10000,
    parameter int c_MIN_SPEED        = 20000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    input  logic               i_VSync,
    input  logic               i_Game_Start,
`ifdef GAME_PAUSE_EN
    input  logic               i_Pause,
`endif
    input  logic               i_Collision,
    input  logic               i_Reached_Top,
    output logic               o_Game_Active,
    output logic               o_Freeze,
    output logic               o_Respawn,
    output logic [SPEED_W-1:0] o_Car_Speed,
    output logic [LEVEL_W-1:0] o_Level,
    output logic [LIVES_W-1:0] o_Lives,
    output logic [SCORE_W-1:0] o_Score,
    output logic [2:0]         o_State
);

    game_state_e        r_State, w_State_Next;
    logic [LIVES_W-1:0] r_Lives, w_Lives_Next;
    logic [LEVEL_W-1:0] r_Level, w_Level_Next;
    logic [SCORE_W-1:0] r_Score, w_Score_Next;
    logic [SPEED_W-1:0] r_Car_Speed;
    logic               r_Respawn, w_Respawn;
    logic               r_Start_Prev;
    logic               w_Start_Edge;
    logic               w_Load;
    logic [FRAME_W-1:0] w_Load_Value;
    logic               w_Tick, w_Done, w_Frame_End;

`ifdef GAME_PAUSE_EN
    logic r_Pause_Prev;
    logic w_Pause_Edge;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_Pause_Prev <= 1'b0;
        end else begin
            r_Pause_Prev <= i_Pause;
        end
    end

    assign w_Pause_Edge = i_Pause & ~r_Pause_Prev;
`endif

    frame_timer u_frame_timer (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_VSync (i_VSync),
        .i_Load  (w_Load),
        .i_Value (w_Load_Value),
        .o_Tick  (w_Tick),
        .o_Done  (w_Done)
    );

    assign w_Start_Edge = i_Game_Start & ~r_Start_Prev;
    assign w_Frame_End  = w_Tick & w_Done;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State      <= ST_IDLE;
            r_Lives      <= LIVES_W'(c_LIVES);
            r_Level      <= '0;
            r_Score      <= '0;
            r_Respawn    <= 1'b0;
            r_Start_Prev <= 1'b0;
            r_Car_Speed  <= SPEED_W'(c_BASE_SPEED);
        end else begin
            r_State      <= w_State_Next;
            r_Lives      <= w_Lives_Next;
            r_Level      <= w_Level_Next;
            r_Score      <= w_Score_Next;
            r_Respawn    <= w_Respawn;
            r_Start_Prev <= i_Game_Start;
            // Follows the level register, so it trails a level change by one clock.
            r_Car_Speed  <= speed_for_level(r_Level, c_BASE_SPEED, c_SPEED_STEP, c_MIN_SPEED);
        end
    end

    always_comb begin
        w_State_Next = r_State;
        w_Load       = 1'b0;
        w_Load_Value = FRAME_W'(c_COUNTDOWN_FRAMES);
        w_Respawn    = 1'b0;
        w_Lives_Next = r_Lives;
        w_Level_Next = r_Level;
        w_Score_Next = r_Score;
        case (r_State)
            ST_IDLE, ST_GAME_OVER: begin
                if (w_Start_Edge) begin
                    w_State_Next = ST_COUNTDOWN;
                    w_Load       = 1'b1;
                    w_Respawn    = 1'b1;
                    w_Lives_Next = LIVES_W'(c_LIVES);
                    w_Level_Next = '0;
                    w_Score_Next = '0;
                end
            end
            ST_COUNTDOWN: begin
                if (w_Frame_End) begin
                    w_State_Next = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                // Reaching the top beats a simultaneous collision.
                if (i_Reached_Top) begin
                    w_State_Next = ST_WIN;
                    w_Load       = 1'b1;
                    w_Load_Value = FRAME_W'(c_WIN_FRAMES);
                    w_Score_Next = (r_Score == {SCORE_W{1'b1}}) ? r_Score : r_Score + 1'b1;
                    w_Level_Next = (r_Level == LEVEL_W'(c_MAX_LEVEL)) ? r_Level : r_Level + 1'b1;
                end else if (i_Collision) begin
                    w_State_Next = ST_HIT;
                    w_Load       = 1'b1;
                    w_Load_Value = FRAME_W'(c_HIT_FRAMES);
                    w_Lives_Next = r_Lives - 1'b1;
                end
`ifdef GAME_PAUSE_EN
                else if (w_Pause_Edge) begin
                    w_State_Next = ST_PAUSED;
                end
`endif
            end
            ST_HIT: begin
                if (w_Frame_End) begin
                    if (r_Lives == '0) begin
                        w_State_Next = ST_GAME_OVER;
                    end else begin
                        w_State_Next = ST_COUNTDOWN;
                        w_Load       = 1'b1;
                        w_Respawn    = 1'b1;
                    end
                end
            end
            ST_WIN: begin
                if (w_Frame_End) begin
                    w_State_Next = ST_COUNTDOWN;
                    w_Load       = 1'b1;
                    w_Respawn    = 1'b1;
                end
            end
`ifdef GAME_PAUSE_EN
            ST_PAUSED: begin
                if (w_Pause_Edge) begin
                    w_State_Next = ST_RUNNING;
                end
            end
`endif
            default: w_State_Next = ST_IDLE;
        endcase
    end

    assign o_Game_Active = (r_State == ST_RUNNING);
    assign o_Freeze      = (r_State == ST_COUNTDOWN) || (r_State == ST_HIT) ||
                           (r_State == ST_WIN)       || (r_State == ST_PAUSED);
    assign o_Respawn     = r_Respawn;
    assign o_Car_Speed   = r_Car_Speed;
    assign o_Level       = r_Level;
    assign o_Lives       = r_Lives;
    assign o_Score       = r_Score;
    assign o_State       = r_State;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed round scenarios plus random play, checked
// every cycle against a frame-counting model of the game rules.
module tb_game_flow_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b0;
    logic start = 1'b0;
    logic coll = 1'b0;
    logic top = 1'b0;

    logic        a_active, a_freeze, a_respawn;
    logic [23:0] a_speed;
    logic [2:0]  a_level, a_lives, a_state;
    logic [7:0]  a_score;
    logic        b_active, b_freeze, b_respawn;
    logic [23:0] b_speed;
    logic [2:0]  b_level, b_lives, b_state;
    logic [7:0]  b_score;

    int n_vec = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    game_flow_ctrl dut_a (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_VSync(vsync), .i_Game_Start(start),
        .i_Collision(coll), .i_Reached_Top(top),
        .o_Game_Active(a_active), .o_Freeze(a_freeze), .o_Respawn(a_respawn),
        .o_Car_Speed(a_speed), .o_Level(a_level), .o_Lives(a_lives),
        .o_Score(a_score), .o_State(a_state)
    );

    // Same stimulus with a steeper step so the speed floor is reached.
    game_flow_ctrl #(.c_SPEED_STEP(20000)) dut_b (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_VSync(vsync), .i_Game_Start(start),
        .i_Collision(coll), .i_Reached_Top(top),
        .o_Game_Active(b_active), .o_Freeze(b_freeze), .o_Respawn(b_respawn),
        .o_Car_Speed(b_speed), .o_Level(b_level), .o_Lives(b_lives),
        .o_Score(b_score), .o_State(b_state)
    );

    // ---------------- reference model ----------------
    int m_state, m_frames, m_lives, m_level, m_score, m_speed, m_speed2;
    bit m_respawn, m_vs_prev, m_st_prev;

    function automatic int exp_speed(input int level, input int step);
        int v;
        v = 100000 - level * step;
        return (v < 20000) ? 20000 : v;
    endfunction

    always @(posedge clk) begin : model
        bit vs_edge, st_edge;
        int lvl_old;
        vs_edge = vsync && !m_vs_prev;
        st_edge = start && !m_st_prev;
        lvl_old = m_level;
        if (!rst_n) begin
            m_state = 0; m_frames = 0; m_lives = 3; m_level = 0; m_score = 0;
            m_speed = 100000; m_speed2 = 100000; m_respawn = 0;
            m_vs_prev = 0; m_st_prev = 0;
        end else begin
            m_respawn = 0;
            case (m_state)
                0, 5: if (st_edge) begin
                    m_state = 1; m_frames = 120; m_respawn = 1;
                    m_lives = 3; m_level = 0; m_score = 0;
                end
                1: if (vs_edge) begin
                    if (m_frames == 1) m_state = 2;
                    else m_frames--;
                end
                2: if (top) begin
                    m_state = 4; m_frames = 90;
                    if (m_score < 255) m_score++;
                    if (m_level < 7) m_level++;
                end else if (coll) begin
                    m_state = 3; m_frames = 60; m_lives--;
                end
                3: if (vs_edge) begin
                    if (m_frames == 1) begin
                        if (m_lives == 0) m_state = 5;
                        else begin m_state = 1; m_frames = 120; m_respawn = 1; end
                    end else m_frames--;
                end
                4: if (vs_edge) begin
                    if (m_frames == 1) begin m_state = 1; m_frames = 120; m_respawn = 1; end
                    else m_frames--;
                end
                default: m_state = 0;
            endcase
            m_speed  = exp_speed(lvl_old, 10000);
            m_speed2 = exp_speed(lvl_old, 20000);
            m_vs_prev = vsync;
            m_st_prev = start;
        end
    end

    // ---------------- VSync source: frames of 5..7 clocks ----------------
    initial begin
        forever begin
            int len, hi;
            len = $urandom_range(5, 7);
            hi  = $urandom_range(1, 2);
            for (int i = 0; i < len; i++) begin
                @(posedge clk);
                #1 vsync = (i < hi);
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            cmp("state",   a_state,   m_state);
            cmp("active",  a_active,  m_state == 2);
            cmp("freeze",  a_freeze,  m_state == 1 || m_state == 3 || m_state == 4);
            cmp("respawn", a_respawn, m_respawn);
            cmp("level",   a_level,   m_level);
            cmp("lives",   a_lives,   m_lives);
            cmp("score",   a_score,   m_score);
            cmp("speed",   a_speed,   m_speed);
            cmp("speed_b", b_speed,   m_speed2);
        end
    endtask

    task automatic wait_state(input int s, input int budget, input string what);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (a_state == 3'(s)) return;
        end
        cmp(what, a_state, s);
    endtask

    task automatic pulse(input logic c, input logic t);
        @(posedge clk); #1 coll = c; top = t;
        @(posedge clk); #1 coll = 1'b0; top = 1'b0;
        @(negedge clk);
    endtask

    task automatic press_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_one();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        cmp({tag, "_state"},   a_state,   0);
        cmp({tag, "_active"},  a_active,  0);
        cmp({tag, "_freeze"},  a_freeze,  0);
        cmp({tag, "_respawn"}, a_respawn, 0);
        cmp({tag, "_level"},   a_level,   0);
        cmp({tag, "_lives"},   a_lives,   3);
        cmp({tag, "_score"},   a_score,   0);
        cmp({tag, "_speed"},   a_speed,   100000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int resp, entries;
        logic [2:0] prev_state;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fork
            compare_loop();
        join_none
        @(negedge clk);
        check_reset_values("reset");

        // Held start: exactly one entry and one respawn, then play.
        @(posedge clk); #1 start = 1'b1;
        resp = 0; entries = 0; prev_state = a_state;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (a_respawn) resp++;
            if (a_state == 3'd1 && prev_state != 3'd1) entries++;
            prev_state = a_state;
        end
        cmp("hold_respawns", resp, 1);
        cmp("hold_entries", entries, 1);
        cmp("hold_active", a_active, 1);
        @(posedge clk); #1 start = 1'b0;

        // Collision at three lives.
        wait_state(2, 1500, "wait_run1");
        pulse(1'b1, 1'b0);
        cmp("hit_state", a_state, 3);
        cmp("hit_lives", a_lives, 2);
        cmp("hit_freeze", a_freeze, 1);
        wait_state(1, 600, "wait_cd_after_hit");
        cmp("hit_respawn", a_respawn, 1);

        // Two more collisions end the game.
        for (int i = 0; i < 2; i++) begin
            wait_state(2, 1500, "wait_run_hit");
            pulse(1'b1, 1'b0);
        end
        wait_state(5, 600, "wait_game_over");
        cmp("go_lives", a_lives, 0);
        cmp("go_active", a_active, 0);
        cmp("go_freeze", a_freeze, 0);
        press_start();
        cmp("restart_state", a_state, 1);
        cmp("restart_lives", a_lives, 3);
        cmp("restart_score", a_score, 0);

        // Win and collision together: win wins.
        wait_state(2, 1500, "wait_run_win");
        pulse(1'b1, 1'b1);
        cmp("win_state", a_state, 4);
        cmp("win_score", a_score, 1);
        cmp("win_level", a_level, 1);
        cmp("win_lives", a_lives, 3);
        cmp("win_speed_lag", a_speed, 100000);
        @(negedge clk);
        cmp("win_speed", a_speed, 90000);

        // Seven more wins: level saturates at 7.
        for (int i = 0; i < 7; i++) begin
            wait_state(2, 3000, "wait_run_wins");
            pulse(1'b0, 1'b1);
        end
        cmp("sat_level", a_level, 7);
        cmp("sat_score", a_score, 8);
        repeat (2) @(negedge clk);
        cmp("sat_speed", a_speed, 30000);
        cmp("floor_speed", b_speed, 20000);

        // Reset inside WIN at score 5.
        reset_one();
        press_start();
        for (int i = 0; i < 5; i++) begin
            wait_state(2, 3000, "wait_run_score5");
            pulse(1'b0, 1'b1);
        end
        cmp("win5_state", a_state, 4);
        cmp("win5_score", a_score, 5);
        reset_one();
        check_reset_values("midreset");

        // Random play.
        for (int i = 0; i < 6000; i++) begin
            @(posedge clk); #1;
            start = ($urandom_range(0, 19) == 0);
            coll  = ($urandom_range(0, 39) == 0);
            top   = ($urandom_range(0, 59) == 0);
            rst_n = !($urandom_range(0, 2499) == 0);
        end
        @(posedge clk); #1;
        start = 1'b0; coll = 1'b0; top = 1'b0; rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
